regfile_mp_sb: RTL

- Parametrised successor register file for the pipelined core.
- Provides XLEN-wide registers with NUM_RD combinational read ports and two write ports: WB0 for the ALU path and WB1 for the load path.
- Register 0 is hardwired to zero.
- An integrated scoreboard tracks registers with outstanding producers, so decode can detect RAW hazards without a separate unit.
- Writes occur on the rising clock edge. Optional same-cycle write-to-read bypass.

---
 rtl/regfile_mp_sb_if.sv | 33 +++
 rtl/regfile_mp_sb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: bus bundle between the pipelined core and regfile_mp_sb.
//   rd_addr/rd_data/rd_busy : NUM_RD combinational read ports (port k in slice k)
//   wr_en/wr_addr/wr_data   : WB0 (ALU) in the low slice, WB1 (load) in the high slice
//   iss_en/iss_addr         : destination of the instruction issuing this cycle
//   pending_cnt/any_busy    : scoreboard occupancy
// master = core side, slave = register file side.
interface regfile_mp_sb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 6
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [1:0]               wr_en;
    logic [2*ADDR_W-1:0]      wr_addr;
    logic [2*XLEN-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [CNT_W-1:0]         pending_cnt;
    logic                     any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, pending_cnt, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, pending_cnt, any_busy
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with integrated RAW scoreboard.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : regfile_mp_sb_if.slave (read ports, WB0/WB1 write ports,
//              issue port, pending_cnt/any_busy)
// Register 0 is hardwired to zero and never busy. WB1 wins over WB0 on a
// same-address write; an issue wins over a write-clear of the same register.
// Optional macro REGFILE_BYPASS_EN: forwards active write data to the read
// ports in the same cycle and masks rd_busy for a register being written.

// One read port: stored-state lookup plus optional write forwarding.
module regfile_mp_sb_rdport #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic                               i_rst,
    input  logic [ADDR_W-1:0]                  i_addr,
    input  logic [2**ADDR_W-1:0][XLEN-1:0]     i_regs,
    input  logic [2**ADDR_W-1:0]               i_busy,
    input  logic [1:0]                         i_we,      // already qualified with addr != 0
    input  logic [ADDR_W-1:0]                  i_wa0,
    input  logic [ADDR_W-1:0]                  i_wa1,
    input  logic [XLEN-1:0]                    i_wd0,
    input  logic [XLEN-1:0]                    i_wd1,
    input  logic                               i_iss,     // already qualified with addr != 0
    input  logic [ADDR_W-1:0]                  i_iss_addr,
    output logic [XLEN-1:0]                    o_data,
    output logic                               o_busy
);
    logic w_nz;
    assign w_nz = (i_addr != '0);

`ifdef REGFILE_BYPASS_EN
    logic w_hit0, w_hit1, w_iss_hit;
    assign w_hit0    = i_we[0] && (i_wa0 == i_addr);
    assign w_hit1    = i_we[1] && (i_wa1 == i_addr);
    assign w_iss_hit = i_iss && (i_iss_addr == i_addr);

    always_comb begin
        o_data = '0;
        o_busy = 1'b0;
        if (!i_rst && w_nz) begin
            if (w_hit1)      o_data = i_wd1;
            else if (w_hit0) o_data = i_wd0;
            else             o_data = i_regs[i_addr];
            // A producer completing now clears the hazard unless a new
            // producer for the same register is issuing in the same cycle.
            o_busy = ((w_hit0 || w_hit1) && !w_iss_hit) ? 1'b0 : i_busy[i_addr];
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_we, i_wa0, i_wa1, i_wd0, i_wd1, i_iss, i_iss_addr};

    always_comb begin
        o_data = '0;
        o_busy = 1'b0;
        if (!i_rst && w_nz) begin
            o_data = i_regs[i_addr];
            o_busy = i_busy[i_addr];
        end
    end
`endif
endmodule

module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 6
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0][XLEN-1:0]  r_regs;
    logic [NREGS-1:0]            r_busy;
    logic [NREGS-1:0]            w_busy_nxt;
    logic [CNT_W-1:0]            r_cnt;

    logic [ADDR_W-1:0]           w_wa0, w_wa1, w_iss_addr;
    logic [XLEN-1:0]             w_wd0, w_wd1;
    logic                        w_we0, w_we1, w_iss;
    logic                        w_inc, w_dec0, w_dec1;
    logic [NUM_RD-1:0][XLEN-1:0] w_rd_data;
    logic [NUM_RD-1:0]           w_rd_busy;

    assign w_wa0      = bus.wr_addr[0 +: ADDR_W];
    assign w_wa1      = bus.wr_addr[ADDR_W +: ADDR_W];
    assign w_wd0      = bus.wr_data[0 +: XLEN];
    assign w_wd1      = bus.wr_data[XLEN +: XLEN];
    assign w_iss_addr = bus.iss_addr;

    // Address-0 traffic is dropped here so nothing downstream sees it.
    assign w_we0 = bus.wr_en[0] && (w_wa0 != '0);
    assign w_we1 = bus.wr_en[1] && (w_wa1 != '0);
    assign w_iss = bus.iss_en && (w_iss_addr != '0);

    // Clears first, then the issue set, so set wins on the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we0) w_busy_nxt[w_wa0] = 1'b0;
        if (w_we1) w_busy_nxt[w_wa1] = 1'b0;
        if (w_iss) w_busy_nxt[w_iss_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Incremental occupancy: count only real 0->1 / 1->0 transitions.
    // WB1 does not decrement again when WB0 already clears the same register.
    assign w_inc  = w_iss && !r_busy[w_iss_addr];
    assign w_dec0 = w_we0 && r_busy[w_wa0] && !(w_iss && (w_iss_addr == w_wa0));
    assign w_dec1 = w_we1 && r_busy[w_wa1] && !(w_iss && (w_iss_addr == w_wa1))
                    && !(w_we0 && (w_wa0 == w_wa1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            // WB1 assigned last so it wins a same-address collision.
            if (w_we0) r_regs[w_wa0] <= w_wd0;
            if (w_we1) r_regs[w_wa1] <= w_wd1;
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec0) - CNT_W'(w_dec1);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_mp_sb_rdport #(
            .XLEN   (XLEN),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .i_rst      (rst),
            .i_addr     (bus.rd_addr[k*ADDR_W +: ADDR_W]),
            .i_regs     (r_regs),
            .i_busy     (r_busy),
            .i_we       ({w_we1, w_we0}),
            .i_wa0      (w_wa0),
            .i_wa1      (w_wa1),
            .i_wd0      (w_wd0),
            .i_wd1      (w_wd1),
            .i_iss      (w_iss),
            .i_iss_addr (w_iss_addr),
            .o_data     (w_rd_data[k]),
            .o_busy     (w_rd_busy[k])
        );
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.rd_busy     = w_rd_busy;
    assign bus.pending_cnt = r_cnt;
    assign bus.any_busy    = (r_cnt != '0);
endmodule
